pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_ctrl_sat_cnt32.sv | 20 ++
 rtl/pipe_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM encoding,
// timeout default and the NOP instruction word used by flushed stages.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MD_WAIT   = 2'd1,
    ST_BUS_DRAIN = 2'd2,
    ST_BUS_GRANT = 2'd3
  } state_t;

  localparam int          MD_TIMEOUT_DEF = 64;
  localparam int          TO_CNT_W       = 8;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_sat_cnt32.sv
// 32-bit saturating event counter with synchronous clear (clear beats increment).
module sat_cnt32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 32'd0;
    end else if (clr) begin
      value <= 32'd0;
    end else if (inc && (value != 32'hFFFF_FFFF)) begin
      value <= value + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: jump flushes, multi-cycle op stalls with timeout, and
// quiesce/grant handshake for an external bus master.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        md_start_i,
  input  logic        md_done_i,
  input  logic        bus_req_i,
  input  logic        cnt_clr_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        bus_gnt_o,
  output logic        md_err_o,
  output logic [31:0] stall_cnt_o,
  output state_t      state_o
);

  state_t                state_q, state_d;
  logic [TO_CNT_W-1:0]   md_cnt_q, md_cnt_d;
  logic                  stall;

  assign jump_addr_o  = jump_addr_i;
  assign pc_hold_o    = stall;
  assign if_id_hold_o = stall;
  assign state_o      = state_q;

  always_comb begin
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    stall         = 1'b0;
    jump_en_o     = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    md_err_o      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (jump_en_i) begin
          jump_en_o     = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (md_start_i) begin
          stall    = 1'b1;
          md_cnt_d = '0;
          state_d  = ST_MD_WAIT;
        end else if (bus_req_i) begin
          stall   = 1'b1;
          state_d = ST_BUS_DRAIN;
        end
      end
      ST_MD_WAIT: begin
        md_cnt_d = md_cnt_q + 1'b1;
        // A completing op wins over a coincident timeout.
        if (md_done_i) begin
          stall   = bus_req_i;
          state_d = bus_req_i ? ST_BUS_GRANT : ST_RUN;
        end else if (md_cnt_q == TO_CNT_W'(MD_TIMEOUT - 1)) begin
          md_err_o = 1'b1;
          state_d  = ST_RUN;
        end else begin
          stall = 1'b1;
        end
      end
      ST_BUS_DRAIN: begin
        stall   = bus_req_i;
        state_d = bus_req_i ? ST_BUS_GRANT : ST_RUN;
      end
      ST_BUS_GRANT: begin
        stall = 1'b1;
        if (!bus_req_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (stall) id_ex_flush_o = 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_RUN;
      md_cnt_q  <= '0;
      bus_gnt_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      bus_gnt_o <= (state_d == ST_BUS_GRANT);
    end
  end

  sat_cnt32 u_stall_cnt (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .inc   (stall),
    .clr   (cnt_clr_i),
    .value (stall_cnt_o)
  );

endmodule
